bus_str_bfm: RTL and testbench
==============================

BUS_STR_BFM -- requirements
Module: bus_str_bfm

Interface
REQ-001 SHALL have parameter BAW, default 8, bus address width.
REQ-002 SHALL have parameter BDW, default 32, bus data width.
REQ-003 SHALL have parameter SDW, default 32, source stream data width.
REQ-004 SHALL have parameter DDW, default 34, drain stream data width (event+sample).
REQ-005 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port cmd_valid  in  1  bus write command request.
REQ-008 SHALL have port cmd_ready  out  1  bus write command accepted.
REQ-009 SHALL have port cmd_addr  in  BAW  command address.
REQ-010 SHALL have port cmd_data  in  BDW  command data.
REQ-011 SHALL have port bus_wvalid  out  1  bus write valid.
REQ-012 SHALL have port bus_wready  in  1  bus write ready.
REQ-013 SHALL have port bus_waddr  out  BAW  bus write address.
REQ-014 SHALL have port bus_wdata  out  BDW  bus write data.
REQ-015 SHALL have port src_valid  in  1  source sample request.
REQ-016 SHALL have port src_ready  out  1  source sample accepted.
REQ-017 SHALL have port src_data  in  SDW  source sample.
REQ-018 SHALL have port sti_tvalid  out  1  output stream valid.
REQ-019 SHALL have port sti_tready  in  1  output stream ready.
REQ-020 SHALL have port sti_tdata  out  SDW  output stream data.
REQ-021 SHALL have port drn_en  in  1  drain enable.
REQ-022 SHALL have port sto_tvalid  in  1  drained stream valid.
REQ-023 SHALL have port sto_tready  out  1  drained stream ready.
REQ-024 SHALL have port sto_tdata  in  DDW  drained stream data ({event, sample}).
REQ-025 SHALL have port drn_valid  out  1  one-cycle capture strobe.
REQ-026 SHALL have port drn_data  out  DDW  last captured drained word.

Function
REQ-027 Bus channel SHALL drive cmd_ready = !bus_wvalid | bus_wready (combinational).
REQ-028 On cmd_valid & cmd_ready, next edge SHALL load bus_waddr/bus_wdata and set bus_wvalid=1 (1-cycle latency).
REQ-029 On bus_wvalid & bus_wready with no new accept, bus_wvalid SHALL clear next edge.
REQ-030 While bus_wvalid & !bus_wready, bus_waddr/bus_wdata SHALL stay stable; back-to-back accepts SHALL sustain one write per cycle.
REQ-031 Source channel SHALL behave identically: src_ready = !sti_tvalid | sti_tready; src_data -> sti_tdata with 1-cycle latency.
REQ-032 Drain SHALL register sto_tready <= drn_en (1-cycle latency).
REQ-033 On sto_tvalid & sto_tready, next edge SHALL load drn_data <= sto_tdata and pulse drn_valid high for exactly one cycle per transfer.
REQ-034 drn_data SHALL hold its value between transfers.
REQ-035 The three channels SHALL be fully independent; simultaneous events on all three SHALL each complete in the same cycle.

Reset
REQ-036 rst low SHALL asynchronously clear bus_wvalid, sti_tvalid, sto_tready, drn_valid, bus_waddr, bus_wdata, sti_tdata, drn_data and counters to 0.
REQ-037 Reset mid-transfer SHALL drop the pending word; no data replay after release; first accept possible on the first edge after release.

Configuration
REQ-038 With BUS_STR_BFM_CNT_EN defined, SHALL add outputs bus_cnt, src_cnt, drn_cnt (16 bits each) counting completed handshakes, wrapping 0xFFFF -> 0x0000.
REQ-039 Without BUS_STR_BFM_CNT_EN, these ports and their logic SHALL be absent.

Verification
REQ-040 cmd 0x00/0x00000001, bus_wready=1 -> bus_wvalid high one cycle later with addr 0x00, data 0x00000001, then low.
REQ-041 cmd 0x04/0x76543210, bus_wready low 3 cycles -> wvalid/addr/data held, cmd_ready=0 for 3 cycles, completes on 4th.
REQ-042 src_data 0x76543210, sti_tready=1 -> sti_tdata=0x76543210 valid exactly one cycle.
REQ-043 drn_en=1, sto_tdata=0x1_76543210 -> drn_valid one-cycle pulse, drn_data=0x176543210.
REQ-044 rst low while bus_wvalid=1 and stalled -> bus_wvalid=0 immediately, no re-issue after release.
REQ-045 With BUS_STR_BFM_CNT_EN: 65536 writes -> bus_cnt returns to 0x0000.

Source files
------------

// File: rtl/bus_str_bfm_if.sv
// Handshake bundle for bus_str_bfm: command-to-bus write channel, source-to-stream
// channel and drain channel. The master modport is the BFM side; the slave modport is the environment side.
interface bus_str_bfm_if #(
  parameter int BAW = 8,
  parameter int BDW = 32,
  parameter int SDW = 32,
  parameter int DDW = 34
) ();
  logic           cmd_valid;
  logic           cmd_ready;
  logic [BAW-1:0] cmd_addr;
  logic [BDW-1:0] cmd_data;
  logic           bus_wvalid;
  logic           bus_wready;
  logic [BAW-1:0] bus_waddr;
  logic [BDW-1:0] bus_wdata;
  logic           src_valid;
  logic           src_ready;
  logic [SDW-1:0] src_data;
  logic           sti_tvalid;
  logic           sti_tready;
  logic [SDW-1:0] sti_tdata;
  logic           drn_en;
  logic           sto_tvalid;
  logic           sto_tready;
  logic [DDW-1:0] sto_tdata;
  logic           drn_valid;
  logic [DDW-1:0] drn_data;

  modport master (
    input  cmd_valid, cmd_addr, cmd_data, bus_wready,
    input  src_valid, src_data, sti_tready,
    input  drn_en, sto_tvalid, sto_tdata,
    output cmd_ready, bus_wvalid, bus_waddr, bus_wdata,
    output src_ready, sti_tvalid, sti_tdata,
    output sto_tready, drn_valid, drn_data
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_data, bus_wready,
    output src_valid, src_data, sti_tready,
    output drn_en, sto_tvalid, sto_tdata,
    input  cmd_ready, bus_wvalid, bus_waddr, bus_wdata,
    input  src_ready, sti_tvalid, sti_tdata,
    input  sto_tready, drn_valid, drn_data
  );
endinterface

// File: rtl/bus_str_bfm.sv
// Bus/stream BFM: three independent single-register channels (bus write, source stream, drain capture).
// Define BUS_STR_BFM_CNT_EN to add 16-bit wrapping handshake counters bus_cnt/src_cnt/drn_cnt.
module bus_str_bfm #(
  parameter int BAW = 8,
  parameter int BDW = 32,
  parameter int SDW = 32,
  parameter int DDW = 34
) (
  input  logic                 clk,
  input  logic                 rst,
  bus_str_bfm_if.master        bus
`ifdef BUS_STR_BFM_CNT_EN
  ,
  output logic [15:0]          bus_cnt,
  output logic [15:0]          src_cnt,
  output logic [15:0]          drn_cnt
`endif
);

  logic           bus_vld_p1;
  logic [BAW-1:0] bus_waddr_p1;
  logic [BDW-1:0] bus_wdata_p1;
  logic           sti_vld_p1;
  logic [SDW-1:0] sti_tdata_p1;
  logic           sto_rdy_p1;
  logic           drn_vld_p1;
  logic [DDW-1:0] drn_data_p1;

  logic bus_acc_p0;
  logic src_acc_p0;
  logic drn_acc_p0;

  // Accept side: a slot is free when empty or draining this cycle.
  assign bus.cmd_ready = !bus_vld_p1 | bus.bus_wready;
  assign bus.src_ready = !sti_vld_p1 | bus.sti_tready;
  assign bus_acc_p0    = bus.cmd_valid & bus.cmd_ready;
  assign src_acc_p0    = bus.src_valid & bus.src_ready;
  assign drn_acc_p0    = bus.sto_tvalid & sto_rdy_p1;

  // Stage p1: registered channel outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_vld_p1   <= 1'b0;
      bus_waddr_p1 <= '0;
      bus_wdata_p1 <= '0;
      sti_vld_p1   <= 1'b0;
      sti_tdata_p1 <= '0;
      sto_rdy_p1   <= 1'b0;
      drn_vld_p1   <= 1'b0;
      drn_data_p1  <= '0;
    end else begin
      if (bus_acc_p0) begin
        bus_vld_p1   <= 1'b1;
        bus_waddr_p1 <= bus.cmd_addr;
        bus_wdata_p1 <= bus.cmd_data;
      end else if (bus.bus_wready) begin
        bus_vld_p1   <= 1'b0;
      end

      if (src_acc_p0) begin
        sti_vld_p1   <= 1'b1;
        sti_tdata_p1 <= bus.src_data;
      end else if (bus.sti_tready) begin
        sti_vld_p1   <= 1'b0;
      end

      sto_rdy_p1 <= bus.drn_en;
      drn_vld_p1 <= drn_acc_p0;
      if (drn_acc_p0) begin
        drn_data_p1 <= bus.sto_tdata;
      end
    end
  end

  assign bus.bus_wvalid = bus_vld_p1;
  assign bus.bus_waddr  = bus_waddr_p1;
  assign bus.bus_wdata  = bus_wdata_p1;
  assign bus.sti_tvalid = sti_vld_p1;
  assign bus.sti_tdata  = sti_tdata_p1;
  assign bus.sto_tready = sto_rdy_p1;
  assign bus.drn_valid  = drn_vld_p1;
  assign bus.drn_data   = drn_data_p1;

`ifdef BUS_STR_BFM_CNT_EN
  // Completed-handshake counters; natural 16-bit wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_cnt <= '0;
      src_cnt <= '0;
      drn_cnt <= '0;
    end else begin
      if (bus_vld_p1 & bus.bus_wready) bus_cnt <= bus_cnt + 16'd1;
      if (sti_vld_p1 & bus.sti_tready) src_cnt <= src_cnt + 16'd1;
      if (drn_acc_p0)                  drn_cnt <= drn_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bus_str_bfm.sv
// Directed bench for bus_str_bfm with per-channel scoreboard queues checked by a negedge monitor.
module tb_bus_str_bfm;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   sb_off = 1'b0;

  logic [39:0] bus_q[$];
  logic [31:0] src_q[$];
  logic [33:0] drn_q[$];

  bus_str_bfm_if #(.BAW(8), .BDW(32), .SDW(32), .DDW(34)) bif ();

`ifdef BUS_STR_BFM_CNT_EN
  logic [15:0] bus_cnt, src_cnt, drn_cnt;
`endif

  bus_str_bfm #(.BAW(8), .BDW(32), .SDW(32), .DDW(34)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
`ifdef BUS_STR_BFM_CNT_EN
    ,
    .bus_cnt (bus_cnt),
    .src_cnt (src_cnt),
    .drn_cnt (drn_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every completed transfer pops and compares.
  always @(negedge clk) begin
    logic [39:0] eb;
    logic [31:0] es;
    logic [33:0] ed;
    if (rst && !sb_off) begin
      if (bif.bus_wvalid && bif.bus_wready) begin
        chk("bus_expected", 64'(bus_q.size() != 0), 64'd1);
        if (bus_q.size() != 0) begin
          eb = bus_q.pop_front();
          chk("bus_addr_sb", 64'(bif.bus_waddr), 64'(eb[39:32]));
          chk("bus_data_sb", 64'(bif.bus_wdata), 64'(eb[31:0]));
        end
      end
      if (bif.sti_tvalid && bif.sti_tready) begin
        chk("sti_expected", 64'(src_q.size() != 0), 64'd1);
        if (src_q.size() != 0) begin
          es = src_q.pop_front();
          chk("sti_data_sb", 64'(bif.sti_tdata), 64'(es));
        end
      end
      if (bif.drn_valid) begin
        chk("drn_expected", 64'(drn_q.size() != 0), 64'd1);
        if (drn_q.size() != 0) begin
          ed = drn_q.pop_front();
          chk("drn_data_sb", 64'(bif.drn_data), 64'(ed));
        end
      end
    end
  end

  initial begin
    logic [31:0] d;
    bif.cmd_valid = 0; bif.cmd_addr = '0; bif.cmd_data = '0; bif.bus_wready = 0;
    bif.src_valid = 0; bif.src_data = '0; bif.sti_tready = 0;
    bif.drn_en = 0; bif.sto_tvalid = 0; bif.sto_tdata = '0;

    // Reset state
    #3;
    chk("rst_wvalid", 64'(bif.bus_wvalid), 64'd0);
    chk("rst_waddr",  64'(bif.bus_waddr), 64'd0);
    chk("rst_wdata",  64'(bif.bus_wdata), 64'd0);
    chk("rst_tvalid", 64'(bif.sti_tvalid), 64'd0);
    chk("rst_tdata",  64'(bif.sti_tdata), 64'd0);
    chk("rst_stordy", 64'(bif.sto_tready), 64'd0);
    chk("rst_drnvld", 64'(bif.drn_valid), 64'd0);
    chk("rst_drndat", 64'(bif.drn_data), 64'd0);
    chk("rst_cmdrdy", 64'(bif.cmd_ready), 64'd1);
    step();
    rst = 1;
    step();

    // Single write, ready high
    bif.cmd_valid = 1; bif.cmd_addr = 8'h00; bif.cmd_data = 32'h1; bif.bus_wready = 1;
    bus_q.push_back({8'h00, 32'h1});
    step();
    bif.cmd_valid = 0;
    chk("w1_valid", 64'(bif.bus_wvalid), 64'd1);
    chk("w1_addr",  64'(bif.bus_waddr), 64'h0);
    chk("w1_data",  64'(bif.bus_wdata), 64'h1);
    step();
    chk("w1_clear", 64'(bif.bus_wvalid), 64'd0);

    // Stalled write: held 3 cycles, completes on the 4th
    bif.bus_wready = 0;
    bif.cmd_valid = 1; bif.cmd_addr = 8'h04; bif.cmd_data = 32'h76543210;
    bus_q.push_back({8'h04, 32'h76543210});
    step();
    bif.cmd_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 64'(bif.bus_wvalid), 64'd1);
      chk("stall_addr",  64'(bif.bus_waddr), 64'h04);
      chk("stall_data",  64'(bif.bus_wdata), 64'h76543210);
      chk("stall_cmdrdy", 64'(bif.cmd_ready), 64'd0);
      step();
    end
    bif.bus_wready = 1;
    #1;
    chk("stall_rel_rdy", 64'(bif.cmd_ready), 64'd1);
    step();
    chk("stall_done", 64'(bif.bus_wvalid), 64'd0);

    // Back-to-back writes at full rate
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      bif.cmd_valid = 1; bif.cmd_addr = 8'(8'h10 + i); bif.cmd_data = d;
      bus_q.push_back({8'(8'h10 + i), d});
      step();
      chk("b2b_valid", 64'(bif.bus_wvalid), 64'd1);
      chk("b2b_addr",  64'(bif.bus_waddr), 64'(8'h10 + i));
    end
    bif.cmd_valid = 0;
    step();
    chk("b2b_clear", 64'(bif.bus_wvalid), 64'd0);
    chk("b2b_q", 64'(bus_q.size()), 64'd0);

    // Source channel
    bif.src_valid = 1; bif.src_data = 32'h76543210; bif.sti_tready = 1;
    src_q.push_back(32'h76543210);
    step();
    bif.src_valid = 0;
    chk("src_valid", 64'(bif.sti_tvalid), 64'd1);
    chk("src_data",  64'(bif.sti_tdata), 64'h76543210);
    step();
    chk("src_clear", 64'(bif.sti_tvalid), 64'd0);

    // Drain capture
    bif.drn_en = 1;
    chk("drn_rdy_lat", 64'(bif.sto_tready), 64'd0);
    step();
    chk("drn_rdy", 64'(bif.sto_tready), 64'd1);
    bif.sto_tvalid = 1; bif.sto_tdata = 34'h176543210;
    drn_q.push_back(34'h176543210);
    step();
    bif.sto_tvalid = 0; bif.sto_tdata = 34'h0AAAAAAAA;
    chk("drn_pulse", 64'(bif.drn_valid), 64'd1);
    chk("drn_data",  64'(bif.drn_data), 64'h176543210);
    step();
    chk("drn_pulse_end", 64'(bif.drn_valid), 64'd0);
    chk("drn_hold",      64'(bif.drn_data), 64'h176543210);

    // All three channels in the same cycle
    bif.cmd_valid = 1; bif.cmd_addr = 8'h20; bif.cmd_data = 32'hA5A5A5A5;
    bif.src_valid = 1; bif.src_data = 32'h5A5A5A5A;
    bif.sto_tvalid = 1; bif.sto_tdata = 34'h2_12345678;
    bus_q.push_back({8'h20, 32'hA5A5A5A5});
    src_q.push_back(32'h5A5A5A5A);
    drn_q.push_back(34'h2_12345678);
    step();
    bif.cmd_valid = 0; bif.src_valid = 0; bif.sto_tvalid = 0;
    chk("sim_bus", 64'(bif.bus_wvalid), 64'd1);
    chk("sim_sti", 64'(bif.sti_tvalid), 64'd1);
    chk("sim_drn", 64'(bif.drn_valid), 64'd1);
    step();

    // Drain disabled: no capture
    bif.drn_en = 0;
    step();
    chk("drn_off_rdy", 64'(bif.sto_tready), 64'd0);
    bif.sto_tvalid = 1; bif.sto_tdata = 34'h3_FFFFFFFF;
    step();
    bif.sto_tvalid = 0;
    chk("drn_off_vld", 64'(bif.drn_valid), 64'd0);
    chk("drn_off_hold", 64'(bif.drn_data), 64'h2_12345678);

`ifdef BUS_STR_BFM_CNT_EN
    chk("cnt_bus", 64'(bus_cnt), 64'd7);
    chk("cnt_src", 64'(src_cnt), 64'd2);
    chk("cnt_drn", 64'(drn_cnt), 64'd2);
`endif

    // Reset while a write is stalled
    bif.bus_wready = 0;
    bif.cmd_valid = 1; bif.cmd_addr = 8'h08; bif.cmd_data = 32'hDEADBEEF;
    step();
    bif.cmd_valid = 0;
    chk("pre_rst_valid", 64'(bif.bus_wvalid), 64'd1);
    #2 rst = 0;
    #1;
    chk("async_wvalid", 64'(bif.bus_wvalid), 64'd0);
    chk("async_waddr",  64'(bif.bus_waddr), 64'd0);
    chk("async_wdata",  64'(bif.bus_wdata), 64'd0);
`ifdef BUS_STR_BFM_CNT_EN
    chk("async_cnt", 64'(bus_cnt), 64'd0);
`endif
    bus_q.delete();
    step();
    bif.bus_wready = 1;
    step();
    rst = 1;
    step();
    chk("no_replay", 64'(bif.bus_wvalid), 64'd0);
    bif.cmd_valid = 1; bif.cmd_addr = 8'h0C; bif.cmd_data = 32'hCAFEF00D;
    bus_q.push_back({8'h0C, 32'hCAFEF00D});
    step();
    bif.cmd_valid = 0;
    chk("post_rst_valid", 64'(bif.bus_wvalid), 64'd1);
    chk("post_rst_data",  64'(bif.bus_wdata), 64'hCAFEF00D);
    step();
    chk("post_rst_clear", 64'(bif.bus_wvalid), 64'd0);

`ifdef BUS_STR_BFM_CNT_EN
    chk("cnt_after_rst", 64'(bus_cnt), 64'd1);
    // Counter wrap over 65536 writes
    sb_off = 1;
    rst = 0;
    step();
    rst = 1;
    bif.cmd_valid = 1; bif.cmd_addr = 8'h33; bif.cmd_data = 32'h1;
    for (int i = 0; i < 65536; i++) step();
    bif.cmd_valid = 0;
    step();
    chk("cnt_wrap", 64'(bus_cnt), 64'd0);
    chk("cnt_wrap_idle", 64'(bif.bus_wvalid), 64'd0);
    sb_off = 0;
`endif

    chk("q_bus_empty", 64'(bus_q.size()), 64'd0);
    chk("q_src_empty", 64'(src_q.size()), 64'd0);
    chk("q_drn_empty", 64'(drn_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
